// File: rtl/dlx_pkg.sv
// Shared DLX pipeline definitions: access widths, byte-lane patterns
// and the EX/MEM control bundle.
package dlx_pkg;

    localparam logic [1:0] WIDTH_BYTE = 2'b00;
    localparam logic [1:0] WIDTH_HALF = 2'b01;
    localparam logic [1:0] WIDTH_WORD = 2'b10;

    localparam logic [3:0] BE_NONE = 4'b0000;
    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    typedef enum logic [1:0] {
        W_BYTE = 2'b00,
        W_HALF = 2'b01,
        W_WORD = 2'b10
    } width_e;

    typedef struct packed {
        logic mem2reg;
        logic mem_read;
        logic mem_write;
        logic reg_write;
        logic sign_flag;
        logic valid;
    } ctrl_t;

    // Both 10 and 11 encode a word access.
    function automatic width_e width_kind(input logic [1:0] w);
        if (w[1])
            return W_WORD;
        else if (w[0])
            return W_HALF;
        else
            return W_BYTE;
    endfunction

endpackage

// File: rtl/ex_mem_reg_store_align.sv
// Store-lane replication, byte-enable generation and misalignment
// detection for the EX/MEM boundary; purely combinational.
module store_align
    import dlx_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] data,
    input  logic [1:0]        addr,
    input  logic [1:0]        width,
    input  logic              access,
    output logic [DATA_W-1:0] lane_data,
    output logic [3:0]        byte_en,
    output logic              misaligned
);

    width_e kind;
    logic   raw_mis;

    assign kind = width_kind(width);

    always_comb begin
        lane_data = data;
        byte_en   = BE_WORD;
        raw_mis   = 1'b0;
        unique case (kind)
            W_BYTE: begin
                lane_data = {(DATA_W/8){data[7:0]}};
                byte_en   = BE_BYTE << addr;
            end
            W_HALF: begin
                lane_data = {(DATA_W/16){data[15:0]}};
                byte_en   = BE_HALF << {addr[1], 1'b0};
                raw_mis   = addr[0];
            end
            default: begin
                raw_mis = |addr;
            end
        endcase
    end

    // Only a real memory access can be misaligned.
    assign misaligned = raw_mis & access;

endmodule

// File: rtl/ex_mem_reg.sv
// EX/MEM pipeline register with store alignment, misaligned-access
// squash, sticky halt and a retired-instruction counter.
module ex_mem_reg
    import dlx_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int REG_W  = 5
) (
    input  logic              clk,
    input  logic              i_reset,
    input  logic              i_step,
    input  logic              i_flush,
    input  logic              i_valid,
    input  logic [DATA_W-1:0] i_alu_result,
    input  logic [DATA_W-1:0] i_store_data,
    input  logic [REG_W-1:0]  i_write_reg,
    input  logic              i_mem2Reg,
    input  logic              i_memRead,
    input  logic              i_memWrite,
    input  logic              i_regWrite,
    input  logic              i_sign_flag,
    input  logic              i_halt,
    input  logic [1:0]        i_width,
    output logic [DATA_W-1:0] o_alu_result,
    output logic [DATA_W-1:0] o_store_data,
    output logic [REG_W-1:0]  o_write_reg,
    output logic              o_mem2Reg,
    output logic              o_memRead,
    output logic              o_memWrite,
    output logic              o_regWrite,
    output logic              o_sign_flag,
    output logic              o_valid,
    output logic [1:0]        o_width,
    output logic [3:0]        o_byte_en,
    output logic              o_misaligned,
    output logic              o_halt,
    output logic [31:0]       o_retired_cnt
);

    logic [DATA_W-1:0] lane_data;
    logic [3:0]        lane_be;
    logic              mis;
    logic              access;
    logic              bubble;
    logic              take;
    ctrl_t             ctrl_d;
    logic [3:0]        be_d;

    assign access = (i_memRead | i_memWrite) & i_valid;

    store_align #(
        .DATA_W(DATA_W)
    ) u_align (
        .data      (i_store_data),
        .addr      (i_alu_result[1:0]),
        .width     (i_width),
        .access    (access),
        .lane_data (lane_data),
        .byte_en   (lane_be),
        .misaligned(mis)
    );

    // Once halted, everything after the halt enters MEM as a bubble.
    assign bubble = i_flush | o_halt;
    assign take   = ~bubble & i_valid;

    always_comb begin
        ctrl_d = '0;
        be_d   = BE_NONE;
        if (!bubble) begin
            ctrl_d.mem2reg   = i_mem2Reg;
            ctrl_d.mem_read  = i_memRead & ~mis;
            ctrl_d.mem_write = i_memWrite & ~mis;
            ctrl_d.reg_write = i_regWrite & ~mis;
            ctrl_d.sign_flag = i_sign_flag;
            ctrl_d.valid     = i_valid;
            be_d             = mis ? BE_NONE : lane_be;
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            o_alu_result <= '0;
            o_store_data <= '0;
            o_write_reg  <= '0;
            o_width      <= '0;
        end else if (!i_step) begin
            o_alu_result <= i_alu_result;
            o_store_data <= lane_data;
            o_write_reg  <= i_write_reg;
            o_width      <= i_width;
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            o_mem2Reg    <= 1'b0;
            o_memRead    <= 1'b0;
            o_memWrite   <= 1'b0;
            o_regWrite   <= 1'b0;
            o_sign_flag  <= 1'b0;
            o_valid      <= 1'b0;
            o_byte_en    <= BE_NONE;
            o_misaligned <= 1'b0;
        end else if (!i_step) begin
            o_mem2Reg    <= ctrl_d.mem2reg;
            o_memRead    <= ctrl_d.mem_read;
            o_memWrite   <= ctrl_d.mem_write;
            o_regWrite   <= ctrl_d.reg_write;
            o_sign_flag  <= ctrl_d.sign_flag;
            o_valid      <= ctrl_d.valid;
            o_byte_en    <= be_d;
            o_misaligned <= ~bubble & mis;
        end
    end

    always_ff @(posedge clk or negedge i_reset) begin
        if (!i_reset) begin
            o_halt        <= 1'b0;
            o_retired_cnt <= '0;
        end else if (!i_step && take) begin
            o_retired_cnt <= o_retired_cnt + 32'd1;
            if (i_halt)
                o_halt <= 1'b1;
        end
    end

endmodule

// File: doc/ex_mem_reg.md
EX_MEM_REG -- requirements
Module: ex_mem_reg

Interface
REQ-001 Parameter DATA_W, default 32, datapath width.
REQ-002 Parameter REG_W, default 5, register-index width.
REQ-003 clk  in  1  single clock, rising-edge active.
REQ-004 i_reset  in  1  asynchronous, active-low reset.
REQ-005 i_step  in  1  debug hold; 1 = freeze all state, 0 = run.
REQ-006 i_flush  in  1  turn the incoming EX instruction into a bubble.
REQ-007 i_valid  in  1  EX stage holds a real instruction.
REQ-008 i_alu_result  in  DATA_W  ALU result / effective memory address.
REQ-009 i_store_data  in  DATA_W  forwarded rt value for stores.
REQ-010 i_write_reg  in  REG_W  destination register index.
REQ-011 i_mem2Reg, i_memRead, i_memWrite, i_regWrite, i_sign_flag, i_halt  in  1 each  EX control bits.
REQ-012 i_width  in  2  access width: 00 byte, 01 half, 1x word.
REQ-013 o_alu_result, o_store_data  out  DATA_W  registered address and lane-replicated store data.
REQ-014 o_write_reg  out  REG_W  registered destination index.
REQ-015 o_mem2Reg, o_memRead, o_memWrite, o_regWrite, o_sign_flag, o_valid  out  1 each  registered controls.
REQ-016 o_width  out  2  registered width.
REQ-017 o_byte_en  out  4  registered byte-lane enables.
REQ-018 o_misaligned  out  1  registered misaligned-access flag.
REQ-019 o_halt  out  1  sticky halt-reached flag.
REQ-020 o_retired_cnt  out  32  count of instructions that entered MEM.

Function
REQ-021 Per rising edge, priority SHALL be: reset > i_step=1 (hold everything, including counter and halt) > o_halt=1 > i_flush=1 > normal load.
REQ-022 Normal load SHALL capture all inputs with 1-cycle latency and set o_valid to i_valid.
REQ-023 Bubble (i_flush=1, or o_halt already 1) SHALL load data fields but clear every control output, o_byte_en, o_misaligned and o_valid, and SHALL not count.
REQ-024 Byte enables SHALL be 0001<<addr[1:0] for byte, 0011<<{addr[1],0} for half, and 1111 for word, where addr = i_alu_result[1:0].
REQ-025 Store data SHALL be replicated into lanes: byte {4{d[7:0]}}, half {2{d[15:0]}}, word d.
REQ-026 Misaligned SHALL be (half & addr[0]) | (word & addr[1:0]!=0), gated by (i_memRead|i_memWrite) & i_valid.
REQ-027 On a misaligned load, o_misaligned SHALL be 1 and o_memRead, o_memWrite, o_regWrite and o_byte_en SHALL be 0; all other fields load normally.
REQ-028 o_retired_cnt SHALL increment by 1 on every non-bubble load with i_valid=1 and SHALL wrap from FFFFFFFF to 0.
REQ-029 o_halt SHALL set on a non-bubble load with i_halt & i_valid; that load SHALL itself count, and o_halt SHALL remain 1 until reset.
REQ-030 i_flush together with i_halt SHALL not set o_halt.

Reset
REQ-031 i_reset=0 SHALL immediately clear every output to 0, including o_retired_cnt and o_halt, regardless of clk or i_step.
REQ-032 Reset asserted mid-operation SHALL discard the in-flight instruction; the first load after release follows REQ-021.

Structure
REQ-033 Width encodings (BYTE, HALF, WORD) and the byte-enable patterns SHALL live in the shared package dlx_pkg.
REQ-034 Lane replication, byte-enable generation and misalignment detection SHALL be one combinational sub-module, store_align; ex_mem_reg holds all registers.

Verification
REQ-035 Byte store: addr=0x1003, data=0x000000AB, width 00 -> o_byte_en=1000, o_store_data=ABABABAB, o_memWrite=1.
REQ-036 Half load: addr=0x2001, width 01 -> o_misaligned=1, o_memRead=0, o_regWrite=0, o_byte_en=0000, count unchanged... see REQ-028: count +1.
REQ-037 Hold/flush: i_step=1 for 3 cycles with changing inputs -> outputs frozen; then i_flush=1 with i_regWrite=1 -> o_regWrite=0, o_valid=0, count unchanged.
REQ-038 Halt: load a halt, then 2 valid adds -> o_halt=1 after the halt, count +1 only, later adds produce bubbles.
REQ-039 Wrap and reset: preload count to FFFFFFFF via 2^32-1 loads (or force), one valid load -> 0; asserting i_reset between edges -> all outputs 0 immediately.
